// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, taken-branch flushes, data-memory freezes.
// Outputs are combinational from state and inputs; `define HAZARD_PERF_CNT_EN builds the stall/flush/freeze counters.
module hazard_control_unit #(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        memwb_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        exmem_flush,
  output logic [1:0]  state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam int         WAIT_INIT = (MEM_WAIT_CYCLES > 1) ? MEM_WAIT_CYCLES - 2 : 0;

  logic [1:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       freeze, load_use, branch;

  assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign branch   = mem_branch_taken;

  // The release cycle (WAIT, counter 0) deliberately ignores the still-present access.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    if (MEM_WAIT_CYCLES > 1) begin
      case (state_q)
        ST_RUN: begin
          if (mem_MemRead || mem_MemWrite) begin
            freeze  = 1'b1;
            wait_d  = 4'(WAIT_INIT);
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_q != 4'd0) begin
            freeze = 1'b1;
            wait_d = wait_q - 4'd1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          wait_d  = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst || freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (branch) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] freeze_count_q, freeze_count_d;
  logic        stall_evt, flush_evt;

  assign stall_evt = !freeze && !branch && load_use;
  assign flush_evt = !freeze && branch;

  // Counters saturate rather than wrap.
  always_comb begin
    stall_count_d  = stall_count_q;
    flush_count_d  = flush_count_q;
    freeze_count_d = freeze_count_q;
    if (stall_evt && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
    if (flush_evt && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
    if (freeze && (freeze_count_q != 32'hFFFF_FFFF))
      freeze_count_d = freeze_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q  <= 32'd0;
      flush_count_q  <= 32'd0;
      freeze_count_q <= 32'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      flush_count_q  <= flush_count_d;
      freeze_count_q <= freeze_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;
  assign freeze_count = freeze_count_q;
`else
  assign stall_count  = 32'd0;
  assign flush_count  = 32'd0;
  assign freeze_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: one single-cycle-memory instance and one 4-cycle-memory instance share inputs.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0;
  logic       mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_branch_taken = 1'b0;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_bub, a_iff, a_emf;
  logic [1:0]  a_state;
  logic [31:0] a_stall, a_flush, a_freeze;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_bub, b_iff, b_emf;
  logic [1:0]  b_state;
  logic [31:0] b_stall, b_flush, b_freeze;

  logic [7:0] ctl1, ctl4;
  assign ctl1 = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_bub, a_iff, a_emf};
  assign ctl4 = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_bub, b_iff, b_emf};

  // {pc,ifid,idex,exmem,memwb writes, bubble, ifid_flush, exmem_flush}
  localparam logic [7:0] ZERO   = 8'b00000_000;
  localparam logic [7:0] NORMAL = 8'b11111_000;
  localparam logic [7:0] FREEZE = 8'b00000_000;
  localparam logic [7:0] STALL  = 8'b00111_100;
  localparam logic [7:0] FLUSH  = 8'b11111_111;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.MEM_WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_branch_taken(mem_branch_taken),
    .pc_write(a_pc), .ifid_write(a_ifid), .idex_write(a_idex), .exmem_write(a_exmem),
    .memwb_write(a_memwb), .idex_bubble(a_bub), .ifid_flush(a_iff), .exmem_flush(a_emf),
    .state(a_state), .stall_count(a_stall), .flush_count(a_flush), .freeze_count(a_freeze)
  );

  hazard_control_unit #(.MEM_WAIT_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_branch_taken(mem_branch_taken),
    .pc_write(b_pc), .ifid_write(b_ifid), .idex_write(b_idex), .exmem_write(b_exmem),
    .memwb_write(b_memwb), .idex_bubble(b_bub), .ifid_flush(b_iff), .exmem_flush(b_emf),
    .state(b_state), .stall_count(b_stall), .flush_count(b_flush), .freeze_count(b_freeze)
  );

  function automatic logic [31:0] perf(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_rt = 5'd0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_branch_taken = 1'b0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    idle();
    #2;
    chk("rst_ctl1", 32'(ctl1), 32'(ZERO));
    chk("rst_ctl4", 32'(ctl4), 32'(ZERO));
    chk("rst_state4", 32'(b_state), 32'd0);
    chk("rst_stall4", b_stall, 32'd0);
    chk("rst_freeze4", b_freeze, 32'd0);
    next(); next();
    rst = 1'b0; #1;
    chk("run_idle1", 32'(ctl1), 32'(NORMAL));
    chk("run_idle4", 32'(ctl4), 32'(NORMAL));

    // load-use: lw $2 in EX, add using $2 in ID
    next(); ex_MemRead = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; #1;
    chk("lu_stall1", 32'(ctl1), 32'(STALL));
    chk("lu_stall4", 32'(ctl4), 32'(STALL));
    next(); idle(); #1;
    chk("lu_after1", 32'(ctl1), 32'(NORMAL));
    chk("lu_after4", 32'(ctl4), 32'(NORMAL));
    chk("lu_cnt4", b_stall, perf(1));

    // $zero never stalls; rt ignored unless used
    next(); ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    chk("zero_nostall", 32'(ctl4), 32'(NORMAL));
    next(); ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
    chk("rt_unused_nostall", 32'(ctl4), 32'(NORMAL));
    next(); id_uses_rt = 1'b1; #1;
    chk("rt_used_stall", 32'(ctl4), 32'(STALL));

    // branch beats load-use
    next(); mem_branch_taken = 1'b1; #1;
    chk("br_flush1", 32'(ctl1), 32'(FLUSH));
    chk("br_flush4", 32'(ctl4), 32'(FLUSH));
    next(); idle(); #1;
    chk("br_stallcnt", b_stall, perf(2));
    chk("br_flushcnt", b_flush, perf(1));

    // 4-cycle memory: 3 freezes, release, RUN
    next(); mem_MemRead = 1'b1; #1;
    chk("fz0_ctl4", 32'(ctl4), 32'(FREEZE));
    chk("fz0_state4", 32'(b_state), 32'd0);
    chk("fz0_ctl1", 32'(ctl1), 32'(NORMAL));
    next(); #1;
    chk("fz1_ctl4", 32'(ctl4), 32'(FREEZE));
    chk("fz1_state4", 32'(b_state), 32'd1);
    next(); #1;
    chk("fz2_ctl4", 32'(ctl4), 32'(FREEZE));
    chk("fz2_state4", 32'(b_state), 32'd1);
    next(); #1;
    chk("rel_ctl4", 32'(ctl4), 32'(NORMAL));
    chk("rel_state4", 32'(b_state), 32'd1);
    next(); mem_MemRead = 1'b0; #1;
    chk("post_ctl4", 32'(ctl4), 32'(NORMAL));
    chk("post_state4", 32'(b_state), 32'd0);
    chk("post_freezecnt4", b_freeze, perf(3));
    chk("post_state1", 32'(a_state), 32'd0);

    // store with a branch held: freeze wins, branch applied at release
    next(); mem_MemWrite = 1'b1; mem_branch_taken = 1'b1; #1;
    chk("fb0_ctl4", 32'(ctl4), 32'(FREEZE));
    chk("fb0_ctl1", 32'(ctl1), 32'(FLUSH));
    next(); #1;
    chk("fb1_ctl4", 32'(ctl4), 32'(FREEZE));
    next(); #1;
    chk("fb2_ctl4", 32'(ctl4), 32'(FREEZE));
    next(); #1;
    chk("fb_rel_ctl4", 32'(ctl4), 32'(FLUSH));
    chk("fb_rel_state4", 32'(b_state), 32'd1);
    next(); idle(); #1;
    chk("fb_state4", 32'(b_state), 32'd0);
    chk("fb_freezecnt4", b_freeze, perf(6));
    chk("fb_flushcnt4", b_flush, perf(2));
    chk("fb_flushcnt1", a_flush, perf(5));
    chk("fb_freezecnt1", a_freeze, 32'd0);

    // reset during the 2nd freeze cycle
    next(); mem_MemRead = 1'b1; #1;
    chk("rw0_ctl4", 32'(ctl4), 32'(FREEZE));
    next(); #1;
    chk("rw1_state4", 32'(b_state), 32'd1);
    rst = 1'b1; #1;
    chk("rw_rst_ctl4", 32'(ctl4), 32'(ZERO));
    chk("rw_rst_state4", 32'(b_state), 32'd0);
    chk("rw_rst_freezecnt", b_freeze, 32'd0);
    chk("rw_rst_flushcnt", b_flush, 32'd0);
    next(); rst = 1'b0; idle(); #1;
    chk("rw_after_ctl4", 32'(ctl4), 32'(NORMAL));
    chk("rw_after_state4", 32'(b_state), 32'd0);
    next(); mem_MemRead = 1'b1; #1;
    chk("rw_refreeze_ctl4", 32'(ctl4), 32'(FREEZE));
    next(); #1;
    chk("rw_refreeze_state4", 32'(b_state), 32'd1);

    // single-cycle memory with continuous sw traffic
    for (int i = 0; i < 5; i++) begin
      next(); idle(); mem_MemWrite = 1'b1; #1;
      chk("sw_ctl1", 32'(ctl1), 32'(NORMAL));
      chk("sw_state1", 32'(a_state), 32'd0);
    end
    chk("sw_freezecnt1", a_freeze, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage MIPS datapath.
- Watches the ID-stage instruction fields, the ID/EX and EX/MEM control bits, and the taken-branch signal from MEM.
- Drives write enables, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles load-use stalls, taken-branch flushes, and multi-cycle data-memory freezes. Freezes are sequenced by an FSM with a wait counter.

Parameters:
- MEM_WAIT_CYCLES, 1: total cycles a data-memory access occupies MEM. Legal range 1..16. Value 1 means single-cycle memory, so the FSM never leaves RUN.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  5  instruction[25:21] of instruction in ID
- id_rt  in  5  instruction[20:16] of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- ex_MemRead  in  1  MemRead bit in ID/EX
- ex_rt  in  5  instruction_20_16 held in ID/EX
- mem_MemRead  in  1  MemRead bit in EX/MEM
- mem_MemWrite  in  1  MemWrite bit in EX/MEM
- mem_branch_taken  in  1  Branch AND Zero in MEM
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write, exmem_write, memwb_write  out  1 each  stage register load enables
- idex_bubble  out  1  zero the 9 control bits (RegDst..RegWrite) entering ID/EX
- ifid_flush, exmem_flush  out  1 each  clear the register to NOP on next edge
- state  out  2  FSM state (RUN=0, WAIT=1)
- stall_count, flush_count, freeze_count  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=RUN, wait counter=0, perf counters=0.
  - All *_write=0, idex_bubble=0, all flushes=0, held while rst=1.
  - Normal outputs resume in the first cycle after release.
- All control outputs are combinational from the current state and inputs. They take effect at the next rising edge (zero-cycle latency).
- Default in RUN, no event: every *_write=1, idex_bubble=0, flushes=0.
- Priority, highest first: rst > freeze > branch flush > load-use stall.
- Freeze: pc_write, ifid_write, idex_write, exmem_write and memwb_write all 0. idex_bubble=0 and flushes=0. The whole pipeline holds.
- Freeze start (MEM_WAIT_CYCLES>1 only):
  - Condition: state RUN and (mem_MemRead|mem_MemWrite).
  - Assert freeze this cycle, load counter=MEM_WAIT_CYCLES-2, go to WAIT.
- WAIT:
  - counter!=0: freeze, decrement counter.
  - counter==0: release cycle. Outputs as in RUN, with branch and load-use evaluated normally. Go to RUN.
  - The access is not re-detected in the release cycle.
  - Total freeze cycles per access = MEM_WAIT_CYCLES-1.
  - Back-to-back memory instructions each incur the full freeze.
- Branch flush (mem_branch_taken=1, not frozen):
  - ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - All *_write stay 1, so the PC loads the branch target.
  - Load-use stall is suppressed in the same cycle.
- Load-use stall (not frozen, no branch):
  - Condition: ex_MemRead and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
  - pc_write=0, ifid_write=0, idex_bubble=1; other writes stay 1.
  - The stall lasts exactly one cycle, because the load moves to MEM.
- Register $zero never causes a stall.
- mem_branch_taken and a memory access cannot coexist in MEM. If both are asserted, freeze wins and the branch is applied in the release cycle.
- Reset asserted mid-WAIT aborts the freeze immediately. State returns to RUN with the counter cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_count +1 per load-use stall cycle.
  - flush_count +1 per branch-flush cycle.
  - freeze_count +1 per freeze cycle.
  - All three are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- Undefined: the three ports remain and are tied to 0; no counter flops exist.

Test Plan:
- lw $2 in EX (ex_MemRead=1, ex_rt=2), ID add with id_rs=2 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle all writes=1, bubble=0.
- ex_rt=0 with ex_MemRead=1 and id_rs=0 -> no stall. Same with ex_rt=5, id_rt=5, id_uses_rt=0 -> no stall.
- mem_branch_taken=1 while a load-use condition is present -> ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; stall_count unchanged and flush_count +1 (macro on).
- MEM_WAIT_CYCLES=4, mem_MemRead=1 in RUN -> 3 freeze cycles (all writes 0), state=WAIT for 3 cycles, release cycle with writes=1, then RUN. freeze_count=3.
- MEM_WAIT_CYCLES=4, rst pulsed during the 2nd freeze cycle -> outputs immediately 0, state=RUN after release, counters cleared, normal writes resume.
- MEM_WAIT_CYCLES=1 with continuous sw traffic -> state never leaves RUN and writes stay 1.
